tt_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises a 4-input, 2-output combinational lab block such as the a,b,c,d → f,g functions. On `start` it drives all 16 input combinations in binary order, holds each for a programmable number of cycles, and samples f and g at the end of each hold. It compares the captured truth tables against parameterised expected values and reports pass/fail, the mismatch count and the first failing index. It sits between the board switches/host and the DUT, replacing the manual stimulus sweep.

---
 rtl/tt_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Drives all 16 {a,b,c,d} combinations into a 4-input/2-output combinational
// block, holds each for HOLD_CYCLES cycles and samples f/g at the end of each
// hold. The captured truth tables are compared against EXP_F/EXP_G, giving a
// pass flag, a mismatch count and the index of the first failing vector.
module tt_sweep_ctrl #(
  parameter int          HOLD_CYCLES = 4,        // legal range 1..255
  parameter logic [15:0] EXP_F       = 16'h6996,
  parameter logic [15:0] EXP_G       = 16'h8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  input  logic        g_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        result_valid,
  output logic        pass,
  output logic [15:0] f_cap,
  output logic [15:0] g_cap,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Terminal value of the hold counter; the sample edge is the last cycle of
  // each hold window, so the DUT always gets HOLD_CYCLES full cycles to settle.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [7:0] hold_cnt;

  logic       hold_end;
  logic       vec_mismatch;
  logic [4:0] mismatch_next;

  // idx is forced back to 0 whenever the sweep leaves APPLY, so the vector
  // outputs come straight from a register and read 0000 outside APPLY.
  assign {a, b, c, d} = idx;

  assign hold_end      = (hold_cnt == HOLD_LAST);
  assign vec_mismatch  = (f_in != EXP_F[idx]) || (g_in != EXP_G[idx]);
  assign mismatch_next = mismatch_cnt + {4'd0, vec_mismatch};

  // Sweep sequencer: state, vector index, hold timing and result capture.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      idx            <= 4'd0;
      hold_cnt       <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      result_valid   <= 1'b0;
      pass           <= 1'b0;
      f_cap          <= 16'd0;
      g_cap          <= 16'd0;
      mismatch_cnt   <= 5'd0;
      first_fail_idx <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // start together with abort is treated as no request at all
          if (start && !abort) begin
            state          <= S_APPLY;
            idx            <= 4'd0;
            hold_cnt       <= 8'd0;
            busy           <= 1'b1;
            result_valid   <= 1'b0;
            pass           <= 1'b0;
            f_cap          <= 16'd0;
            g_cap          <= 16'd0;
            mismatch_cnt   <= 5'd0;
            first_fail_idx <= 4'd0;
          end
        end

        S_APPLY: begin
          if (abort) begin
            // partial captures stay visible but result_valid remains low
            state    <= S_IDLE;
            idx      <= 4'd0;
            hold_cnt <= 8'd0;
            busy     <= 1'b0;
          end else if (hold_end) begin
            f_cap[idx]   <= f_in;
            g_cap[idx]   <= g_in;
            mismatch_cnt <= mismatch_next;
            if (vec_mismatch && (mismatch_cnt == 5'd0)) begin
              first_fail_idx <= idx;
            end
            hold_cnt <= 8'd0;
            if (idx == 4'd15) begin
              state        <= S_DONE;
              idx          <= 4'd0;
              busy         <= 1'b0;
              done         <= 1'b1;
              result_valid <= 1'b1;
              pass         <= (mismatch_next == 5'd0);
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        // DONE lasts exactly one cycle; an unused encoding also recovers here
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl
// Directed bench for tt_sweep_ctrl. Four instances with HOLD_CYCLES = 1..4
// share clock and reset; each has its own start/abort. A behavioural lab block
// (f = a^b^c^d, g = a&b&c&d, with tie-off and glitch options) feeds each one.
// Inputs change and outputs are sampled on the falling edge; cyc counts the
// cycle index relative to the cycle in which start was sampled.
module tb_tt_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        start_v [4];
  logic        abort_v [4];
  logic        f_in_v  [4];
  logic        g_in_v  [4];
  logic        a_v     [4];
  logic        b_v     [4];
  logic        c_v     [4];
  logic        d_v     [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic        rv_v    [4];
  logic        pass_v  [4];
  logic [15:0] f_cap_v [4];
  logic [15:0] g_cap_v [4];
  logic [4:0]  mm_v    [4];
  logic [3:0]  ffi_v   [4];

  // lab block behaviour: f_mode 0=xor, 1=tied 0, 2=tied 1; g_mode 0=and, 1=tied 0
  int   f_mode;
  int   g_mode;
  logic f_flip;

  int errors;
  int checks;
  int cyc;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    assign f_in_v[k] = (f_mode == 1) ? 1'b0 :
                       (f_mode == 2) ? 1'b1 :
                       (a_v[k] ^ b_v[k] ^ c_v[k] ^ d_v[k] ^ f_flip);
    assign g_in_v[k] = (g_mode == 1) ? 1'b0 : (a_v[k] & b_v[k] & c_v[k] & d_v[k]);

    tt_sweep_ctrl #(
      .HOLD_CYCLES(k + 1),
      .EXP_F      (16'h6996),
      .EXP_G      (16'h8000)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start_v[k]),
      .abort         (abort_v[k]),
      .f_in          (f_in_v[k]),
      .g_in          (g_in_v[k]),
      .a             (a_v[k]),
      .b             (b_v[k]),
      .c             (c_v[k]),
      .d             (d_v[k]),
      .busy          (busy_v[k]),
      .done          (done_v[k]),
      .result_valid  (rv_v[k]),
      .pass          (pass_v[k]),
      .f_cap         (f_cap_v[k]),
      .g_cap         (g_cap_v[k]),
      .mismatch_cnt  (mm_v[k]),
      .first_fail_idx(ffi_v[k])
    );
  end

  function automatic logic [3:0] vec(input int k);
    return {a_v[k], b_v[k], c_v[k], d_v[k]};
  endfunction

  // every output of one instance packed together; all-zero after reset
  function automatic logic [48:0] all_out(input int k);
    return {a_v[k], b_v[k], c_v[k], d_v[k], busy_v[k], done_v[k], rv_v[k],
            pass_v[k], f_cap_v[k], g_cap_v[k], mm_v[k], ffi_v[k]};
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // start sampled in cycle 0; returns in cycle 1 with start released unless keep
  task automatic launch(input int k, input bit keep);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    cyc = 1;
    if (!keep) start_v[k] = 1'b0;
  endtask

  // bounded wait for done; done_cyc = -1 if the budget runs out
  task automatic wait_done(input int k, input int budget, output int done_cyc);
    done_cyc = -1;
    while (cyc <= budget) begin
      if (done_v[k] === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    settle(3);
    rst = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (all_out(k) !== 49'd0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %h expected 0", k, all_out(k));
      end
    end
  endtask

  task automatic test_golden();
    int dc;
    f_mode = 0; g_mode = 0;
    launch(0, 1'b0);
    checks++;
    if ({busy_v[0], vec(0)} !== 5'b1_0000) begin
      errors++;
      $display("FAIL golden_cycle1: busy/vec=%b expected 10000", {busy_v[0], vec(0)});
    end
    wait_done(0, 40, dc);
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL golden_done_cycle: got %0d expected 17", dc); end
    checks++;
    if (f_cap_v[0] !== 16'h6996) begin errors++; $display("FAIL golden_f_cap: got %h expected 6996", f_cap_v[0]); end
    checks++;
    if (g_cap_v[0] !== 16'h8000) begin errors++; $display("FAIL golden_g_cap: got %h expected 8000", g_cap_v[0]); end
    checks++;
    if ({mm_v[0], pass_v[0], rv_v[0], busy_v[0]} !== 8'b00000_1_1_0) begin
      errors++;
      $display("FAIL golden_flags: mm/pass/rv/busy=%b expected 00000110", {mm_v[0], pass_v[0], rv_v[0], busy_v[0]});
    end
    tick();
    checks++;
    if ({done_v[0], rv_v[0], pass_v[0]} !== 3'b011) begin
      errors++;
      $display("FAIL golden_after_done: done/rv/pass=%b expected 011", {done_v[0], rv_v[0], pass_v[0]});
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    f_mode = 0; g_mode = 0;
    launch(0, 1'b1);
    wait_done(0, 40, dc);
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 17", dc); end
    tick();  // cycle 18: start was seen in DONE and must have been ignored
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_idle_c18: busy=%b expected 0", busy_v[0]); end
    tick();  // cycle 19: start accepted in cycle 18
    checks++;
    if ({busy_v[0], rv_v[0]} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_restart_c19: busy/rv=%b expected 10", {busy_v[0], rv_v[0]});
    end
    start_v[0] = 1'b0;
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    checks++;
    if ({busy_v[0], vec(0)} !== 5'b0_0000) begin
      errors++;
      $display("FAIL b2b_abort_cleanup: busy/vec=%b expected 00000", {busy_v[0], vec(0)});
    end
  endtask

  task automatic test_fault_detect();
    int dc;
    f_mode = 0; g_mode = 1;
    launch(1, 1'b0);
    wait_done(1, 60, dc);
    checks++;
    if (dc !== 33) begin errors++; $display("FAIL fault_done_cycle: got %0d expected 33", dc); end
    checks++;
    if ({f_cap_v[1], g_cap_v[1]} !== {16'h6996, 16'h0000}) begin
      errors++;
      $display("FAIL fault_caps: f/g=%h/%h expected 6996/0000", f_cap_v[1], g_cap_v[1]);
    end
    checks++;
    if ({mm_v[1], ffi_v[1], pass_v[1], rv_v[1]} !== {5'd1, 4'd15, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fault_flags: mm=%0d ffi=%0d pass=%b rv=%b expected 1 15 0 1",
               mm_v[1], ffi_v[1], pass_v[1], rv_v[1]);
    end
    g_mode = 0;
    settle(2);
  endtask

  task automatic test_multi_fault();
    int dc;
    f_mode = 2; g_mode = 0;
    launch(0, 1'b0);
    wait_done(0, 40, dc);
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL multi_done_cycle: got %0d expected 17", dc); end
    checks++;
    if (f_cap_v[0] !== 16'hFFFF) begin errors++; $display("FAIL multi_f_cap: got %h expected ffff", f_cap_v[0]); end
    checks++;
    if ({mm_v[0], ffi_v[0], pass_v[0]} !== {5'd8, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL multi_flags: mm=%0d ffi=%0d pass=%b expected 8 0 0", mm_v[0], ffi_v[0], pass_v[0]);
    end
    f_mode = 0;
    settle(2);
  endtask

  task automatic test_abort();
    bit saw_done;
    f_mode = 0; g_mode = 0;
    launch(3, 1'b1);
    while (cyc < 8) tick();
    checks++;
    if ({busy_v[3], vec(3)} !== 5'b1_0001) begin
      errors++;
      $display("FAIL abort_c8: busy/vec=%b expected 10001", {busy_v[3], vec(3)});
    end
    tick();  // cycle 9
    checks++;
    if ({busy_v[3], vec(3)} !== 5'b1_0010) begin
      errors++;
      $display("FAIL abort_c9: busy/vec=%b expected 10010", {busy_v[3], vec(3)});
    end
    start_v[3] = 1'b0;
    abort_v[3] = 1'b1;
    tick();  // cycle 10
    abort_v[3] = 1'b0;
    checks++;
    if ({busy_v[3], vec(3)} !== 5'b0_0000) begin
      errors++;
      $display("FAIL abort_c10: busy/vec=%b expected 00000", {busy_v[3], vec(3)});
    end
    saw_done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done_v[3] === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done: done pulsed, expected none"); end
    checks++;
    if ({rv_v[3], pass_v[3], f_cap_v[3]} !== {1'b0, 1'b0, 16'h0002}) begin
      errors++;
      $display("FAIL abort_results: rv=%b pass=%b f_cap=%h expected 0 0 0002",
               rv_v[3], pass_v[3], f_cap_v[3]);
    end
  endtask

  task automatic test_hold_timing();
    int          dc;
    logic [15:0] snap;
    f_mode = 0; g_mode = 0; f_flip = 1'b0;
    launch(2, 1'b0);
    while (cyc < 15) tick();
    checks++;
    if (vec(2) !== 4'd4) begin errors++; $display("FAIL hold_c15: vec=%b expected 0100", vec(2)); end
    tick();  // cycle 16
    f_flip = 1'b1;
    checks++;
    if (vec(2) !== 4'd5) begin errors++; $display("FAIL hold_c16: vec=%b expected 0101", vec(2)); end
    tick();  // cycle 17
    checks++;
    if (vec(2) !== 4'd5) begin errors++; $display("FAIL hold_c17: vec=%b expected 0101", vec(2)); end
    tick();  // cycle 18
    f_flip = 1'b0;
    checks++;
    if (vec(2) !== 4'd5) begin errors++; $display("FAIL hold_c18: vec=%b expected 0101", vec(2)); end
    tick();  // cycle 19
    snap = f_cap_v[2];
    checks++;
    if ({vec(2), snap[5]} !== {4'd6, 1'b0}) begin
      errors++;
      $display("FAIL hold_c19: vec=%b f_cap[5]=%b expected 0110 0", vec(2), snap[5]);
    end
    wait_done(2, 70, dc);
    checks++;
    if (dc !== 49) begin errors++; $display("FAIL hold_done_cycle: got %0d expected 49", dc); end
    checks++;
    if ({f_cap_v[2], mm_v[2], pass_v[2]} !== {16'h6996, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL hold_results: f_cap=%h mm=%0d pass=%b expected 6996 0 1",
               f_cap_v[2], mm_v[2], pass_v[2]);
    end
    settle(2);
  endtask

  task automatic test_reset_midsweep();
    int dc;
    f_mode = 0; g_mode = 0;
    launch(3, 1'b0);
    while (cyc < 20) tick();
    checks++;
    if ({busy_v[3], vec(3), f_cap_v[3]} !== {1'b1, 4'd4, 16'h0006}) begin
      errors++;
      $display("FAIL rst_pre_c20: busy=%b vec=%b f_cap=%h expected 1 0100 0006",
               busy_v[3], vec(3), f_cap_v[3]);
    end
    rst = 1'b1;
    tick();  // cycle 21
    checks++;
    if (all_out(3) !== 49'd0) begin errors++; $display("FAIL rst_c21: got %h expected 0", all_out(3)); end
    tick();  // cycle 22
    rst = 1'b0;
    checks++;
    if (all_out(3) !== 49'd0) begin errors++; $display("FAIL rst_c22: got %h expected 0", all_out(3)); end
    launch(3, 1'b0);
    checks++;
    if ({busy_v[3], vec(3)} !== 5'b1_0000) begin
      errors++;
      $display("FAIL rst_fresh_c1: busy/vec=%b expected 10000", {busy_v[3], vec(3)});
    end
    wait_done(3, 100, dc);
    checks++;
    if ({dc, pass_v[3], f_cap_v[3]} !== {32'd65, 1'b1, 16'h6996}) begin
      errors++;
      $display("FAIL rst_fresh_sweep: done_cycle=%0d pass=%b f_cap=%h expected 65 1 6996",
               dc, pass_v[3], f_cap_v[3]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    f_mode = 0;
    g_mode = 0;
    f_flip = 1'b0;
    rst    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
    end

    test_reset();
    test_golden();
    test_back_to_back();
    test_fault_detect();
    test_multi_fault();
    test_abort();
    test_hold_timing();
    test_reset_midsweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global safety net in case a wait loop is ever broken
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
